// File: rtl/rpn_engine.sv
// RPN evaluator driving a LIFO stack: pushes operands, pops two per operator,
// computes the result and pushes it back while reporting results and errors.
module rpn_engine #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                       Clk,
    input  logic                       RstN,
    input  logic                       Tok_Valid,
    output logic                       Tok_Ready,
    input  logic [2:0]                 Tok_Op,
    input  logic [WIDTH-1:0]           Tok_Data,
    output logic                       Stk_Push,
    output logic                       Stk_Pop,
    output logic [WIDTH-1:0]           Stk_Data,
    input  logic [WIDTH-1:0]           Stk_Q,
    input  logic                       Stk_Full,
    input  logic                       Stk_NotEmpty,
    output logic                       Res_Valid,
    output logic [WIDTH-1:0]           Res_Data,
    output logic                       Err,
    output logic [1:0]                 Err_Code,
    output logic [$clog2(DEPTH+1)-1:0] Depth
);
    localparam int DW = $clog2(DEPTH+1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PUSH  = 3'd1;
    localparam logic [2:0] S_POPB  = 3'd2;
    localparam logic [2:0] S_POPA  = 3'd3;
    localparam logic [2:0] S_WAITA = 3'd4;
    localparam logic [2:0] S_PUSHR = 3'd5;

    localparam logic [2:0] OP_PUSH = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;

    logic [2:0]       state_q, state_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic [WIDTH-1:0] sdata_q, sdata_d;
    logic [WIDTH-1:0] res_q,   res_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [2:0]       op_q,    op_d;
    logic [1:0]       code_q,  code_d;
    logic             err_q,   err_d;
    logic [WIDTH-1:0] alu_r;

    // Occupancy is tracked locally; the stack's empty flag is not needed.
    logic unused_notempty;
    assign unused_notempty = Stk_NotEmpty;

    // Stk_Q carries A (the deeper operand) during WAITA.
    always_comb begin
        case (op_q)
            OP_ADD:  alu_r = Stk_Q + b_q;
            OP_SUB:  alu_r = Stk_Q - b_q;
            OP_AND:  alu_r = Stk_Q & b_q;
            OP_OR:   alu_r = Stk_Q | b_q;
            OP_XOR:  alu_r = Stk_Q ^ b_q;
            default: alu_r = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        sdata_d = sdata_q;
        res_d   = res_q;
        b_d     = b_q;
        op_d    = op_q;
        code_d  = code_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Tok_Valid) begin
                    if (Tok_Op == OP_PUSH) begin
                        if (depth_q < DW'(DEPTH) && !Stk_Full) begin
                            sdata_d = Tok_Data;
                            state_d = S_PUSH;
                        end else begin
                            err_d  = 1'b1;
                            code_d = 2'b10;
                        end
                    end else if (Tok_Op[2:1] == 2'b11) begin
                        err_d  = 1'b1;
                        code_d = 2'b11;
                    end else if (depth_q >= DW'(2)) begin
                        op_d    = Tok_Op;
                        state_d = S_POPB;
                    end else begin
                        err_d  = 1'b1;
                        code_d = 2'b01;
                    end
                end
            end
            S_PUSH: begin
                depth_d = depth_q + DW'(1);
                state_d = S_IDLE;
            end
            S_POPB:  state_d = S_POPA;
            S_POPA: begin
                b_d     = Stk_Q;
                state_d = S_WAITA;
            end
            S_WAITA: begin
                sdata_d = alu_r;
                res_d   = alu_r;
                state_d = S_PUSHR;
            end
            S_PUSHR: begin
                depth_d = depth_q - DW'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!RstN) begin
            state_q <= S_IDLE;
            depth_q <= '0;
            sdata_q <= '0;
            res_q   <= '0;
            b_q     <= '0;
            op_q    <= '0;
            code_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            sdata_q <= sdata_d;
            res_q   <= res_d;
            b_q     <= b_d;
            op_q    <= op_d;
            code_q  <= code_d;
            err_q   <= err_d;
        end
    end

    assign Tok_Ready = RstN && (state_q == S_IDLE);
    assign Stk_Push  = RstN && (state_q == S_PUSH || state_q == S_PUSHR);
    assign Stk_Pop   = RstN && (state_q == S_POPB || state_q == S_POPA);
    assign Res_Valid = RstN && (state_q == S_PUSHR);
    assign Stk_Data  = sdata_q;
    assign Res_Data  = res_q;
    assign Err       = err_q;
    assign Err_Code  = code_q;
    assign Depth     = depth_q;
endmodule

// File: tb/tb_rpn_engine.sv
// Scoreboard bench for rpn_engine with a behavioural LIFO stack and a
// queue-based RPN reference model.
module tb_rpn_engine;
    logic       Clk = 1'b0;
    logic       RstN = 1'b0;
    logic       Tok_Valid = 1'b0;
    logic       Tok_Ready;
    logic [2:0] Tok_Op = '0;
    logic [3:0] Tok_Data = '0;
    logic       Stk_Push, Stk_Pop;
    logic [3:0] Stk_Data;
    wire  [3:0] Stk_Q;
    logic       Stk_Full, Stk_NotEmpty;
    logic       Res_Valid, Err;
    logic [3:0] Res_Data;
    logic [1:0] Err_Code;
    logic [3:0] Depth;

    rpn_engine #(.WIDTH(4), .DEPTH(8)) dut (
        .Clk(Clk), .RstN(RstN), .Tok_Valid(Tok_Valid), .Tok_Ready(Tok_Ready),
        .Tok_Op(Tok_Op), .Tok_Data(Tok_Data), .Stk_Push(Stk_Push), .Stk_Pop(Stk_Pop),
        .Stk_Data(Stk_Data), .Stk_Q(Stk_Q), .Stk_Full(Stk_Full),
        .Stk_NotEmpty(Stk_NotEmpty), .Res_Valid(Res_Valid), .Res_Data(Res_Data),
        .Err(Err), .Err_Code(Err_Code), .Depth(Depth)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural stack: Stk_Q valid only the cycle after a pop.
    logic [3:0] mem [8];
    int         cnt = 0;
    logic [3:0] q_r = '0;
    logic       q_v = 1'b0;
    int         npush = 0, npop = 0;
    int         stk_err = 0;
    assign Stk_Q        = q_v ? q_r : 4'bz;
    assign Stk_Full     = (cnt == 8);
    assign Stk_NotEmpty = (cnt != 0);

    always @(posedge Clk) begin
        if (!RstN) begin
            cnt <= 0;
            q_v <= 1'b0;
        end else begin
            q_v <= 1'b0;
            if (Stk_Push) npush <= npush + 1;
            if (Stk_Pop)  npop  <= npop + 1;
            if ((Stk_Push && cnt == 8) || (Stk_Pop && cnt == 0) || (Stk_Push && Stk_Pop))
                stk_err <= stk_err + 1;
            else if (Stk_Pop) begin
                q_r <= mem[cnt-1];
                q_v <= 1'b1;
                cnt <= cnt - 1;
            end else if (Stk_Push) begin
                mem[cnt] <= Stk_Data;
                cnt <= cnt + 1;
            end
        end
    end

    // Reference model and scoreboard.
    typedef struct {
        bit         err;
        logic [1:0] code;
        logic [3:0] data;
    } exp_t;
    exp_t sb[$];
    int   model[$];
    int   lastcode = 0;

    task automatic model_tok(input int op, input int d);
        exp_t e;
        int a, b, r;
        e.err = 1'b0; e.code = '0; e.data = '0;
        if (op == 0) begin
            if (model.size() < 8) begin
                model.push_back(d);
                return;
            end
            lastcode = 2; e.err = 1'b1;
        end else if (op >= 6) begin
            lastcode = 3; e.err = 1'b1;
        end else if (model.size() < 2) begin
            lastcode = 1; e.err = 1'b1;
        end else begin
            b = model.pop_back();
            a = model.pop_back();
            case (op)
                1: r = (a + b) % 16;
                2: r = (a - b + 16) % 16;
                3: r = a & b;
                4: r = a | b;
                default: r = a ^ b;
            endcase
            model.push_back(r);
            e.data = 4'(r);
        end
        e.code = 2'(lastcode);
        sb.push_back(e);
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (RstN && (Res_Valid || Err)) begin
            if (Res_Valid && Err) chk("res_err_overlap", 1, 0);
            if (sb.size() == 0) chk("unexpected_output", 1, 0);
            else begin
                e = sb.pop_front();
                chk("is_err", int'(Err), int'(e.err));
                chk("err_code", int'(Err_Code), int'(e.code));
                if (!e.err) begin
                    chk("res_data", int'(Res_Data), int'(e.data));
                    chk("push_data", int'(Stk_Data), int'(e.data));
                    chk("push_with_res", int'(Stk_Push), 1);
                end
            end
        end
    end

    // Waits for Ready, checks Depth against the model, then issues one token.
    task automatic send(input int op, input int d, output int acc);
        int n = 0;
        @(negedge Clk);
        while (!Tok_Ready && n < 60) begin
            @(negedge Clk);
            n++;
        end
        if (!Tok_Ready) begin
            chk("ready_timeout", 0, 1);
            acc = -1;
            return;
        end
        chk("depth", int'(Depth), model.size());
        Tok_Valid = 1'b1;
        Tok_Op    = 3'(op);
        Tok_Data  = 4'(d);
        @(posedge Clk);
        acc = int'($time / 10);
        model_tok(op, d);
        #1 Tok_Valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge Clk);
        while ((!Tok_Ready || sb.size() != 0) && n < 60) begin
            @(negedge Clk);
            n++;
        end
        chk("drain_sb_empty", sb.size(), 0);
        chk("drain_depth", int'(Depth), model.size());
    endtask

    initial begin
        int t0, t1, p0, q0, n;
        repeat (3) @(negedge Clk);
        chk("rst_ready", int'(Tok_Ready), 0);
        chk("rst_depth", int'(Depth), 0);
        chk("rst_code", int'(Err_Code), 0);
        chk("rst_res", int'(Res_Data), 0);
        chk("rst_stkdata", int'(Stk_Data), 0);
        chk("rst_pushpop", int'(Stk_Push | Stk_Pop | Res_Valid | Err), 0);
        RstN = 1'b1;

        // Basic ADD with latency and access counts.
        send(0, 3, t0); send(0, 5, t0);
        p0 = npop; q0 = npush;
        send(1, 0, t0);
        send(0, 2, t1);
        chk("op_latency", t1 - t0, 5);
        chk("add_pops", npop - p0, 2);
        chk("add_pushes", npush - q0, 2);
        send(0, 7, t0); send(2, 0, t0);
        send(0, 15, t0); send(0, 3, t0); send(1, 0, t0);
        drain();

        // Underflow leaves the stack intact.
        RstN = 1'b0; @(negedge Clk); RstN = 1'b1;
        model.delete(); lastcode = 0;
        send(0, 9, t0);
        drain();
        p0 = npop; q0 = npush;
        send(5, 0, t0);
        drain();
        chk("uflow_no_access", (npop - p0) + (npush - q0), 0);
        send(0, 6, t0); send(5, 0, t0);
        drain();

        // Fill to capacity back-to-back, then overflow.
        RstN = 1'b0; @(negedge Clk); RstN = 1'b1;
        model.delete(); lastcode = 0;
        send(0, 1, t0);
        for (int i = 1; i < 8; i++) begin
            send(0, i + 1, t1);
            chk("push_spacing", t1 - t0, 2);
            t0 = t1;
        end
        drain();
        q0 = npush;
        send(0, 4, t0);
        drain();
        chk("oflow_no_push", npush - q0, 0);

        // Illegal opcode, then a normal AND keeps code 11.
        p0 = npop; q0 = npush;
        send(6, 0, t0);
        drain();
        chk("illegal_no_access", (npop - p0) + (npush - q0), 0);
        send(3, 0, t0);
        drain();
        chk("code_held", int'(Err_Code), 3);

        // Reset during POPA of an OR.
        send(4, 0, t0);
        @(posedge Clk);
        @(negedge Clk);
        RstN = 1'b0;
        @(negedge Clk);
        sb.delete(); model.delete(); lastcode = 0;
        chk("midrst_pop", int'(Stk_Pop), 0);
        chk("midrst_depth", int'(Depth), 0);
        chk("midrst_res", int'(Res_Data), 0);
        chk("midrst_code", int'(Err_Code), 0);
        chk("midrst_ready", int'(Tok_Ready), 0);
        @(negedge Clk);
        chk("midrst_ready2", int'(Tok_Ready), 0);
        RstN = 1'b1;
        @(negedge Clk);
        chk("postrst_ready", int'(Tok_Ready), 1);
        send(0, 1, t0);
        drain();

        // Randomized token stream.
        for (int i = 0; i < 120; i++) begin
            n = int'($urandom_range(0, 9));
            if (n <= 3)      send(0, int'($urandom_range(0, 15)), t0);
            else if (n <= 8) send(n - 3, 0, t0);
            else             send(6 + int'($urandom_range(0, 1)), 0, t0);
        end
        drain();
        chk("stack_protocol", stk_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
